// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_if
// Description : Request/ready data-bus bundle between the memory-access
//               stage (master) and the data memory or bus fabric (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_rdata,
    output bus_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : RV32 memory-access stage. Converts EX/MEM load/store controls
//               into a request/ready bus transaction with byte enables,
//               formats load data for MEM/WB, stalls the pipeline while an
//               access is outstanding, flags misaligned accesses and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        Ex_Mem_Valid,
  input  wire logic        Ex_Mem_MemRead,
  input  wire logic        Ex_Mem_MemWrite,
  input  wire logic [2:0]  Ex_Mem_Funct3,
  input  wire logic [31:0] Ex_Mem_Aluresult,
  input  wire logic [31:0] Ex_Mem_Store_Data,
  output logic             Mem_Stall,
  output logic [31:0]      Mem_Wb_MemRead_Data,
  output logic             Mem_Misaligned,
  output logic             Mem_Bus_Error,
  mem_bus_if.master        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic        r_bus_error;

  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misaligned;
  logic        w_start;
  logic        w_ready;
  logic        w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Decode the EX/MEM request: size, alignment, and whether a bus access starts
  always_comb begin
    w_access     = Ex_Mem_Valid & (Ex_Mem_MemRead | Ex_Mem_MemWrite);
    w_is_byte    = (Ex_Mem_Funct3[1:0] == 2'b00);
    w_is_half    = (Ex_Mem_Funct3[1:0] == 2'b01);
    // funct3 011/110/111 fall into the word case along with 010
    w_misaligned = (w_is_half & Ex_Mem_Aluresult[0]) |
                   (~w_is_byte & ~w_is_half & (Ex_Mem_Aluresult[1:0] != 2'b00));
    w_start      = (r_state == S_IDLE) & w_access & ~w_misaligned;
    w_ready      = (r_state == S_BUSY) & bus.bus_ready;
    w_abort      = (r_state == S_BUSY) & ~bus.bus_ready & ((r_cnt + 16'd1) == c_timeout);
  end

  // Byte enables and lane-replicated write data for the pending access
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = Ex_Mem_Store_Data;
    if (w_is_byte) begin
      w_be    = 4'b0001 << Ex_Mem_Aluresult[1:0];
      w_wdata = {4{Ex_Mem_Store_Data[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << Ex_Mem_Aluresult[1:0];
      w_wdata = {2{Ex_Mem_Store_Data[15:0]}};
    end
  end

  // Align the returned word to bit 0 and extend according to the latched funct3
  always_comb begin
    w_shifted = bus.bus_rdata >> {r_addr_lo, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = bus.bus_rdata;
    endcase
  end

  // Next-state and stall decode; the stall covers the launch cycle and all BUSY cycles
  always_comb begin
    w_state_next = r_state;
    Mem_Stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_BUSY;
          Mem_Stall    = 1'b1;
        end
      end
      S_BUSY: begin
        Mem_Stall = 1'b1;
        if (w_ready || w_abort) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait-cycle counter: cleared on launch, counts BUSY cycles without ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 16'd0;
    end else if (w_start) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_BUSY) && !bus.bus_ready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Latch the bus request fields at launch so they stay stable through BUSY
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_addr_lo   <= 2'd0;
      r_funct3    <= 3'd0;
      r_is_load   <= 1'b0;
    end else begin
      r_bus_req <= (w_state_next == S_BUSY);
      if (w_start) begin
        // A load with MemWrite also set is still just a load
        r_bus_we    <= Ex_Mem_MemWrite & ~Ex_Mem_MemRead;
        r_bus_addr  <= {Ex_Mem_Aluresult[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_addr_lo   <= Ex_Mem_Aluresult[1:0];
        r_funct3    <= Ex_Mem_Funct3;
        r_is_load   <= Ex_Mem_MemRead;
      end
    end
  end

  // Load result: updated only when a load completes or is aborted by timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if (r_is_load && w_ready) begin
      r_rdata <= w_load;
    end else if (r_is_load && w_abort) begin
      r_rdata <= 32'd0;
    end
  end

  // One-cycle status pulses for misalignment and bus timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= (r_state == S_IDLE) & w_access & w_misaligned;
      r_bus_error  <= w_abort;
    end
  end

  assign bus.bus_req          = r_bus_req;
  assign bus.bus_we           = r_bus_we;
  assign bus.bus_addr         = r_bus_addr;
  assign bus.bus_be           = r_bus_be;
  assign bus.bus_wdata        = r_bus_wdata;
  assign Mem_Wb_MemRead_Data  = r_rdata;
  assign Mem_Misaligned       = r_misaligned;
  assign Mem_Bus_Error        = r_bus_error;

endmodule
`default_nettype wire
